// File: rtl/rv_pkg.sv
// Shared definitions for the load/store unit: mem_op encodings, LSU state
// encoding, the default abort timeout and the alignment rule.
package rv_pkg;

  typedef enum logic [2:0] {
    MemNone = 3'b000,
    MemB    = 3'b001,
    MemH    = 3'b010,
    MemW    = 3'b011,
    MemBu   = 3'b101,
    MemHu   = 3'b110
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  localparam int unsigned TimeoutCyclesDefault = 255;

  // Byte accesses can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (mem_op_e'(op))
      MemH, MemHu: return addr_lo[0];
      MemW:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational data alignment: byte enables, store-data replication and
// load lane extraction with sign/zero extension.
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rdata[{addr_lo, 3'b000} +: 8];
    lane_h    = rdata[{addr_lo[1], 4'b0000} +: 16];
    be        = 4'b0000;
    wdata_rep = wdata;
    load_data = rdata;
    case (mem_op_e'(op))
      MemB: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      MemBu: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {24'b0, lane_b};
      end
      MemH: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{lane_h[15]}}, lane_h};
      end
      MemHu: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_data = {16'b0, lane_h};
      end
      MemW: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_lsu_ctrl.sv
// Load/store unit controller: accepts one data access from execute, runs it on
// the data bus with grant/rvalid handshaking and aborts it on timeout.
module rv_lsu_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The counter reads 0 in the first REQ cycle; aborting when it reaches
  // TIMEOUT_CYCLES-2 lands bus_err exactly TIMEOUT_CYCLES cycles after acceptance.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);

  lsu_state_e      state_q;
  logic            we_q;
  logic [2:0]      op_q;
  logic [1:0]      addr_lo_q;
  logic [CntW-1:0] cnt_q;

  logic        legal_rd, legal_wr, legal, misal, accept, timeout;
  logic [2:0]  op_sel;
  logic [1:0]  addr_lo_sel;
  logic [3:0]  be;
  logic [31:0] wdata_rep, load_data;

  always_comb begin
    legal_rd = 1'b0;
    legal_wr = 1'b0;
    case (mem_op_e'(mem_op))
      MemB, MemH, MemW: begin
        legal_rd = mem_to_reg & ~mem_write;
        legal_wr = mem_write & ~mem_to_reg;
      end
      MemBu, MemHu: legal_rd = mem_to_reg & ~mem_write;
      default: ;
    endcase
  end

  assign legal   = legal_rd | legal_wr;
  assign misal   = is_misaligned(mem_op, addr[1:0]);
  assign accept  = (state_q == StIdle) && req_valid && legal && !misal;
  assign stall   = accept || (state_q == StReq) || (state_q == StWait);
  assign timeout = (cnt_q == CntLast);

  // Stores are shaped from the live request at acceptance; loads are extracted
  // using the latched op/lane while the access is in flight.
  assign op_sel      = (state_q == StIdle) ? mem_op : op_q;
  assign addr_lo_sel = (state_q == StIdle) ? addr[1:0] : addr_lo_q;

  rv_lsu_align u_align (
    .op        (op_sel),
    .addr_lo   (addr_lo_sel),
    .wdata     (wdata),
    .rdata     (bus_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      op_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_be      <= 4'b0000;
      bus_wdata   <= 32'h0;
      rdata_out   <= 32'h0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      rdata_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && legal) begin
            if (misal) begin
              misalign <= 1'b1;
            end else begin
              state_q   <= StReq;
              we_q      <= mem_write;
              op_q      <= mem_op;
              addr_lo_q <= addr[1:0];
              cnt_q     <= '0;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be;
              bus_wdata <= wdata_rep;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CntW'(1);
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (we_q) begin
              state_q <= StDone;
            end else if (bus_rvalid) begin
              rdata_out   <= load_data;
              rdata_valid <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StWait;
            end
          end else if (timeout) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state_q <= StIdle;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (bus_rvalid) begin
            rdata_out   <= load_data;
            rdata_valid <= 1'b1;
            state_q     <= StDone;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// Scoreboard bench for rv_lsu_ctrl: directed corner cases plus random accesses
// checked against a byte-level reference model.
module tb_rv_lsu_ctrl;

  localparam int unsigned TO = 255;

  logic        clk, rst_n, req_valid, mem_write, mem_to_reg;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  rv_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .mem_op      (mem_op),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_rd[$];
  int          exp_mis, exp_err;
  int          total, bad;
  int          gd, lat;
  logic [31:0] cur_rdata;
  bit          resp_en, junk_en;
  logic        drop_err, drop_req;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(bit mw, bit m2r, logic [2:0] op);
    if (mw == m2r) return 1'b0;
    if (m2r) return op inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    return op inside {3'd1, 3'd2, 3'd3};
  endfunction

  function automatic int m_size(logic [2:0] op);
    case (op)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] op, logic [31:0] a);
    int s = m_size(op);
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] op, logic [31:0] wd);
    int s = m_size(op);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] a, logic [31:0] rd);
    int s = m_size(op);
    logic [31:0] mask, v;
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v = (rd >> (8 * (a % 4))) & mask;
    if ((op == 3'd1 || op == 3'd2) && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input bit mw, input bit m2r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int g, input int l,
                       input int exp_stall, input int bound);
    bit lg, mis, acc;
    int n;
    bus_exp_t e;
    lg  = m_legal(mw, m2r, op);
    mis = lg && ((a % m_size(op)) != 0);
    acc = lg && !mis;
    gd = g; lat = l; cur_rdata = rd;
    if (acc && resp_en) begin
      e.a = a & ~32'd3; e.we = mw; e.be = m_be(op, a); e.wd = m_wdata(op, wd);
      exp_bus.push_back(e);
      if (!mw) exp_rd.push_back(m_load(op, a, rd));
    end
    if (acc && !resp_en) exp_err++;
    if (mis) exp_mis++;
    @(negedge clk);
    req_valid = 1'b1; mem_write = mw; mem_to_reg = m2r; mem_op = op; addr = a; wdata = wd;
    #2;
    chk("stall_at_request", 32'(stall), 32'(acc));
    if (acc) begin
      n = 1;
      for (int k = 0; k < bound; k++) begin
        @(negedge clk);
        // Requests while busy must be ignored.
        if (junk_en && $urandom_range(0, 1) == 1) begin
          req_valid = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; mem_op = 3'd3; addr = $urandom;
        end else begin
          req_valid = 1'b0;
        end
        #2;
        if (!stall) break;
        n++;
      end
      drop_err = bus_err; drop_req = bus_req;
      chk("stall_cycles", 32'(n), 32'(exp_stall));
      @(negedge clk);
      req_valid = 1'b0;
    end else begin
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom;
      #2;
      chk("stall_after_reject", 32'(stall), 32'd0);
    end
    @(negedge clk);
  endtask

  // ---------------- bus responder ----------------
  bit r_rd;
  int r_l;
  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_en && bus_req) begin
        r_rd = !bus_we; r_l = lat;
        repeat (gd) @(negedge clk);
        bus_gnt = 1'b1;
        if (r_rd) begin
          bus_rdata  = cur_rdata;
          bus_rvalid = (r_l == 0);
        end
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (r_rd && r_l > 0) begin
          repeat (r_l - 1) @(negedge clk);
          bus_rvalid = 1'b1;
          @(negedge clk);
          bus_rvalid = 1'b0; bus_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bus_exp_t mon_e;
  logic [31:0] mon_rd;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus_req && bus_gnt) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus_grant: got addr %h required no access", bus_addr);
        end else begin
          mon_e = exp_bus.pop_front();
          chk("bus_addr", bus_addr, mon_e.a);
          chk("bus_we", 32'(bus_we), 32'(mon_e.we));
          chk("bus_be", 32'(bus_be), 32'(mon_e.be));
          if (mon_e.we) chk("bus_wdata", bus_wdata, mon_e.wd);
        end
      end
      if (rdata_valid) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rdata_valid: got %h required no strobe", rdata_out);
        end else begin
          mon_rd = exp_rd.pop_front();
          chk("rdata_out", rdata_out, mon_rd);
        end
      end
      if (misalign) begin
        total++;
        if (exp_mis == 0) begin
          bad++; $display("FAIL misalign_pulse: got 1 required 0");
        end else exp_mis--;
      end
      if (bus_err) begin
        total++;
        if (exp_err == 0) begin
          bad++; $display("FAIL bus_err_pulse: got 1 required 0");
        end else exp_err--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  bit          rmw;
  logic [2:0]  rop;
  logic [31:0] raddr;
  int          rg, rl;
  logic [2:0]  rd_ops[5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};

  initial begin
    total = 0; bad = 0; exp_mis = 0; exp_err = 0;
    rst_n = 1'b0; req_valid = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; mem_op = 3'd0;
    addr = 32'h0; wdata = 32'h0; resp_en = 1'b1; junk_en = 1'b1; gd = 0; lat = 0;
    cur_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_bus_be", 32'(bus_be), 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_rdata_out", rdata_out, 32'd0);
    chk("reset_pulses", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store byte, immediate grant.
    issue(1, 0, 3'd1, 32'h1003, 32'h0000_00AB, 32'h0, 0, 0, 2, 50);
    // Halfword loads with rvalid three cycles after grant.
    issue(0, 1, 3'd2, 32'h2002, 32'h0, 32'h8001_1234, 0, 3, 5, 50);
    issue(0, 1, 3'd6, 32'h2002, 32'h0, 32'h8001_1234, 0, 3, 5, 50);
    // Misaligned and illegal requests.
    issue(0, 1, 3'd3, 32'h3001, 32'h0, 32'h0, 0, 0, 0, 50);
    issue(0, 1, 3'd2, 32'h3003, 32'h0, 32'h0, 0, 0, 0, 50);
    issue(1, 0, 3'd5, 32'h3000, 32'h1234, 32'h0, 0, 0, 0, 50);
    issue(1, 1, 3'd3, 32'h3000, 32'h1234, 32'h0, 0, 0, 0, 50);
    issue(0, 0, 3'd3, 32'h3000, 32'h1234, 32'h0, 0, 0, 0, 50);
    issue(0, 1, 3'd0, 32'h3000, 32'h0, 32'h0, 0, 0, 0, 50);
    issue(0, 1, 3'd4, 32'h3000, 32'h0, 32'h0, 0, 0, 0, 50);
    issue(0, 1, 3'd7, 32'h3000, 32'h0, 32'h0, 0, 0, 0, 50);

    // Timeout: grant never arrives.
    resp_en = 1'b0; junk_en = 1'b0;
    issue(0, 1, 3'd3, 32'h0000_0040, 32'h0, 32'h0, 0, 0, TO, 400);
    chk("timeout_bus_err", 32'(drop_err), 32'd1);
    chk("timeout_bus_req", 32'(drop_req), 32'd0);
    resp_en = 1'b1; junk_en = 1'b1;

    // Reset while waiting for read data; the late rvalid must be ignored.
    begin
      bus_exp_t e;
      e.a = 32'h5000; e.we = 1'b0; e.be = 4'hF; e.wd = 32'h0;
      exp_bus.push_back(e);
      gd = 0; lat = 6; cur_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      req_valid = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; mem_op = 3'd3; addr = 32'h5000;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #2;
      chk("rst_wait_stall", 32'(stall), 32'd0);
      chk("rst_wait_bus_req", 32'(bus_req), 32'd0);
      chk("rst_wait_rdata", rdata_out, 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #2;
      chk("late_rvalid_ignored", rdata_out, 32'd0);
      @(negedge clk);
    end

    // Randomized accesses.
    for (int t = 0; t < 80; t++) begin
      rg = $urandom_range(0, 3);
      rl = $urandom_range(0, 3);
      raddr = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rmw = 1'($urandom_range(0, 1));
        rop = 3'($urandom_range(0, 7));
        issue(rmw, 1'($urandom_range(0, 1)), rop, raddr, $urandom, $urandom, rg, rl,
              2 + rg + (rmw ? 0 : rl), 50);
      end else begin
        rmw = 1'($urandom_range(0, 1));
        rop = rmw ? 3'($urandom_range(1, 3)) : rd_ops[$urandom_range(0, 4)];
        if ($urandom_range(0, 4) != 0) raddr = raddr & ~32'(m_size(rop) - 1);
        issue(rmw, !rmw, rop, raddr, $urandom, $urandom, rg, rl, 2 + rg + (rmw ? 0 : rl), 50);
      end
    end

    repeat (5) @(negedge clk);
    #2;
    chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    chk("rdata_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("misalign_all_seen", 32'(exp_mis), 32'd0);
    chk("bus_err_all_seen", 32'(exp_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
